fmul_arbiter: RTL and testbench
===============================

// Module: fmul_arbiter
// PURPOSE
//  Shares one FP32 multiplier (fmul) among NREQ requesters using round-robin arbitration.
//  Accepts at most one operation per cycle and pipelines it through fmul_pipe.
//  Returns each result tagged with the requester id, and keeps a sticky per-requester overflow flag.
//  Sits between the FPU issue logic and the fmul datapath.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  LAT   2  cycles from accepting clock edge to rsp_valid (>=1)
// PORTS
//  clk        in   1          clock; all state on rising edge
//  rstn       in   1          asynchronous active-low reset
//  en         in   1          grant enable; 0 blocks new grants, in-flight ops still drain
//  req_valid  in   NREQ       per-requester operation request
//  req_x1     in   NREQ*32    operand 1, requester i at [32*i+:32]
//  req_x2     in   NREQ*32    operand 2, same packing
//  req_ready  out  NREQ       one-hot grant; transfer when req_valid[i]&req_ready[i]
//  rsp_valid  out  1          result valid (no backpressure; consumer must accept)
//  rsp_id     out  IDW        requester index of result, IDW=$clog2(NREQ)
//  rsp_y      out  32         fmul product
//  rsp_ovf    out  1          fmul exponent overflow for this result
//  ovf_flag   out  NREQ       sticky overflow per requester
//  ovf_clr    in   NREQ       clears ovf_flag[i]
//  busy       out  1          1 while any op in flight
// BEHAVIOUR
//  Reset (rstn=0, async):
//   - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_ovf=0, ovf_flag=0, busy=0.
//   - rr pointer=0; all pipeline valid bits cleared.
//   - Ops in flight at reset assertion are discarded; no response is produced for them.
//  Arbitration (combinational):
//   - If en=1, grant the first i with req_valid[i]=1, searching from rr pointer upward with wrap NREQ-1 -> 0.
//   - req_ready is 0 for all requesters when en=0 or no request is pending.
//   - req_ready never depends on rsp_* signals.
//  On a grant edge:
//   - rr <= (granted id + 1) mod NREQ.
//   - With no grant, rr holds.
//  Pipeline (fmul_pipe):
//   - Operands and id are captured at the accept edge, then go through the combinational fmul core.
//   - LAT-1 output registers follow.
//   - Op accepted at edge k gives rsp_valid=1 in the cycle after edge k+LAT-1.
//   - Results come out in acceptance order; throughput is 1 op/cycle; the pipeline never stalls.
//   - rsp_y and rsp_ovf are bit-exact fmul outputs: round-to-nearest, flush-to-zero, saturating exponent.
//   - rsp_y/rsp_ovf/rsp_id hold their last value when rsp_valid=0.
//  Inflight counter: width $clog2(LAT+1)+1.
//   - +1 on accept, -1 on rsp_valid; both in the same cycle leaves it unchanged.
//   - busy = (count != 0).
//   - Count never exceeds LAT; exceeding LAT is an assertion failure.
//  Sticky overflow:
//   - ovf_flag[rsp_id] is set when rsp_valid & rsp_ovf.
//   - ovf_clr[i] clears bit i.
//   - Set and clear on the same bit in the same cycle: set wins.
//  en falling mid-stream: no new grants; outstanding ops still respond after their LAT cycles.
// STRUCTURE
//  fpu_pkg holds:
//   - FP32_W=32.
//   - The fp32_t struct packed {s, e[7:0], m[22:0]}.
//   - The function id_w(n)=$clog2(n).
//  Sub-module fmul_pipe #(LAT, IDW):
//   - Contains the operand register, the fmul instance and LAT-1 result registers.
//   - Carries the valid/id/ovf sideband through every stage.
//  The top level holds the rr arbiter, inflight counter and sticky flags.
// TESTING
//  1 single: req0 0x3F800000*0x40000000 -> rsp_valid at LAT, id=0, y=0x40000000, ovf=0.
//  2 rounding/sign:
//   - req1 0x3FC00000*0x3FC00000 -> y=0x40100000.
//   - req2 0xC0000000*0x40400000 -> y=0xC0C00000.
//  3 fairness: all 4 req_valid held for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses in that id order, back-to-back.
//  4 overflow:
//   - req3 0x7F000000*0x7F000000 -> rsp_ovf=1 and ovf_flag[3]=1, staying set.
//   - ovf_clr[3] pulsed in the same cycle as a new overflow on id 3 -> flag stays 1.
//  5 zero/ftz: req0 0x00000000*0x40000000 -> y=0x00000000; busy=1 for exactly LAT cycles.
//  6 reset mid-flight: rstn low one cycle after 2 accepts -> no rsp_valid afterwards, busy=0, rr=0, ovf_flag=0.
//  Every scenario is repeated with en toggled: no grant while en=0, pending ops still drain.

Source files
------------

// File: rtl/fmul_arbiter_pkg.sv
// Shared FP32 types and helpers for the fmul arbiter slice.
package fpu_pkg;

    localparam int unsigned FP32_W = 32;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
    } fp32_t;

    function automatic int unsigned id_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fmul_arbiter_if.sv
// Request/response bundle between the FPU issue logic and the shared multiplier.
interface fmul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    import fpu_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*FP32_W-1:0] req_x1;
    logic [NREQ*FP32_W-1:0] req_x2;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [FP32_W-1:0]      rsp_y;
    logic                   rsp_ovf;

    modport master (
        output req_valid, req_x1, req_x2,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf
    );

    modport slave (
        input  req_valid, req_x1, req_x2,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf
    );

endinterface

// File: rtl/fmul_arbiter_pipe.sv
// FP32 multiply core (RNE, flush-to-zero, exponent saturates to infinity) and its
// fixed-latency pipeline carrying valid/id/ovf alongside the product.
module fmul
    import fpu_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t y_o,
    output logic  ovf_o
);
    logic [47:0]       prod;
    logic [23:0]       mant;
    logic              grd, stk, up;
    logic [24:0]       rnd;
    logic signed [9:0] ex;

    always_comb begin
        prod = {1'b1, a_i.m} * {1'b1, b_i.m};
        if (prod[47]) begin
            mant = prod[47:24];
            grd  = prod[23];
            stk  = |prod[22:0];
            ex   = $signed({2'b00, a_i.e}) + $signed({2'b00, b_i.e}) - 10'sd126;
        end else begin
            mant = prod[46:23];
            grd  = prod[22];
            stk  = |prod[21:0];
            ex   = $signed({2'b00, a_i.e}) + $signed({2'b00, b_i.e}) - 10'sd127;
        end
        up  = grd & (stk | mant[0]);
        rnd = {1'b0, mant} + {24'd0, up};
        // Rounding carry-out renormalises: mantissa becomes 1.0, exponent bumps.
        if (rnd[24]) begin
            ex  = ex + 10'sd1;
            rnd = rnd >> 1;
        end
        y_o   = '0;
        y_o.s = a_i.s ^ b_i.s;
        ovf_o = 1'b0;
        if (a_i.e == '0 || b_i.e == '0 || ex <= 10'sd0) begin
            y_o.e = '0;
            y_o.m = '0;
        end else if (ex >= 10'sd255) begin
            y_o.e = '1;
            y_o.m = '0;
            ovf_o = 1'b1;
        end else begin
            y_o.e = ex[7:0];
            y_o.m = rnd[22:0];
        end
    end
endmodule

module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned LAT = 2,
    parameter int unsigned IDW = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           vld_i,
    input  logic [IDW-1:0] id_i,
    input  fp32_t          x1_i,
    input  fp32_t          x2_i,
    output logic           vld_o,
    output logic [IDW-1:0] id_o,
    output fp32_t          y_o,
    output logic           ovf_o
);
    logic           s0_vld_q;
    logic [IDW-1:0] s0_id_q;
    fp32_t          s0_x1_q, s0_x2_q;
    fp32_t          f_y;
    logic           f_ovf;

    // Operands only load on accept so an idle pipe keeps presenting the last result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_vld_q <= 1'b0;
            s0_id_q  <= '0;
            s0_x1_q  <= '0;
            s0_x2_q  <= '0;
        end else begin
            s0_vld_q <= vld_i;
            if (vld_i) begin
                s0_id_q <= id_i;
                s0_x1_q <= x1_i;
                s0_x2_q <= x2_i;
            end
        end
    end

    fmul u_fmul (.a_i(s0_x1_q), .b_i(s0_x2_q), .y_o(f_y), .ovf_o(f_ovf));

    if (LAT == 1) begin : g_direct
        assign vld_o = s0_vld_q;
        assign id_o  = s0_id_q;
        assign y_o   = f_y;
        assign ovf_o = f_ovf;
    end else begin : g_regs
        typedef struct packed {
            logic           vld;
            logic [IDW-1:0] id;
            fp32_t          y;
            logic           ovf;
        } res_t;

        res_t res_q [LAT-1];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int unsigned i = 0; i < LAT - 1; i++) res_q[i] <= '0;
            end else begin
                res_q[0].vld <= s0_vld_q;
                if (s0_vld_q) begin
                    res_q[0].id  <= s0_id_q;
                    res_q[0].y   <= f_y;
                    res_q[0].ovf <= f_ovf;
                end
                for (int unsigned i = 1; i < LAT - 1; i++) begin
                    res_q[i].vld <= res_q[i-1].vld;
                    if (res_q[i-1].vld) begin
                        res_q[i].id  <= res_q[i-1].id;
                        res_q[i].y   <= res_q[i-1].y;
                        res_q[i].ovf <= res_q[i-1].ovf;
                    end
                end
            end
        end

        assign vld_o = res_q[LAT-2].vld;
        assign id_o  = res_q[LAT-2].id;
        assign y_o   = res_q[LAT-2].y;
        assign ovf_o = res_q[LAT-2].ovf;
    end
endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin front end sharing one pipelined FP32 multiplier among NREQ requesters,
// with an in-flight counter and sticky per-requester overflow flags.
module fmul_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    fmul_arbiter_if.slave   bus,
    input  logic [NREQ-1:0] ovf_clr,
    output logic [NREQ-1:0] ovf_flag,
    output logic            busy
);
    localparam int unsigned IDW = id_w(NREQ);
    localparam int unsigned CW  = $clog2(LAT + 1) + 1;

    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] flag_q, flag_d;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id;
    int unsigned     idx;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(rr_q) + k) % NREQ;
                if (!gnt_any && bus.req_valid[IDW'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_any) bus.req_ready[gnt_id] = 1'b1;
    end

    fmul_pipe #(.LAT(LAT), .IDW(IDW)) u_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .vld_i (gnt_any),
        .id_i  (gnt_id),
        .x1_i  (bus.req_x1[FP32_W*gnt_id +: FP32_W]),
        .x2_i  (bus.req_x2[FP32_W*gnt_id +: FP32_W]),
        .vld_o (bus.rsp_valid),
        .id_o  (bus.rsp_id),
        .y_o   (bus.rsp_y),
        .ovf_o (bus.rsp_ovf)
    );

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        cnt_d  = cnt_q + CW'(gnt_any) - CW'(bus.rsp_valid);
        flag_d = flag_q & ~ovf_clr;
        if (bus.rsp_valid && bus.rsp_ovf) flag_d[bus.rsp_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q   <= '0;
            cnt_q  <= '0;
            flag_q <= '0;
        end else begin
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign ovf_flag = flag_q;
    assign busy     = (cnt_q != '0);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn) cnt_q <= CW'(LAT));

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: real-arithmetic reference multiplier, queue-based latency
// model checked every cycle, plus directed literal expectations.
module tb_fmul_arbiter;
    import fpu_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic [NREQ-1:0] ovf_clr;
    logic [NREQ-1:0] ovf_flag;
    logic            busy;

    fmul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fmul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .bus      (bus),
        .ovf_clr  (ovf_clr),
        .ovf_flag (ovf_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Reference product computed exactly in double precision, then rounded to FP32 by hand.
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        real         ra, rb, p;
        logic [63:0] bits;
        int          fe;
        logic [24:0] mant;
        logic [28:0] low;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
        ra = $bitstoreal({1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'd0});
        rb = $bitstoreal({1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'd0});
        p    = ra * rb;
        bits = $realtobits(p);
        fe   = int'(bits[62:52]) - 896;
        mant = {2'b01, bits[51:29]};
        low  = bits[28:0];
        if (low > 29'h1000_0000 || (low == 29'h1000_0000 && bits[29])) mant = mant + 25'd1;
        if (mant[24]) begin
            fe   = fe + 1;
            mant = mant >> 1;
        end
        if (fe >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (fe <= 0)   return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(fe), mant[22:0]};
    endfunction

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } op_t;

    op_t             q[$];
    int              m_rr = 0;
    int              cyc = 0;
    int              g;
    logic            exp_valid = 1'b0;
    logic [IDW-1:0]  exp_id = '0;
    logic [31:0]     exp_y = '0;
    logic            exp_ovf = 1'b0;
    logic [NREQ-1:0] exp_flag = '0;
    logic [NREQ-1:0] new_flag;
    logic            exp_busy = 1'b0;
    logic [32:0]     r;

    function automatic int model_grant();
        if (en !== 1'b1) return -1;
        for (int k = 0; k < NREQ; k++)
            if (bus.req_valid[(m_rr + k) % NREQ] === 1'b1) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_rr = 0;
            q.delete();
            exp_valid = 1'b0;
            exp_id = '0;
            exp_y = '0;
            exp_ovf = 1'b0;
            exp_flag = '0;
            exp_busy = 1'b0;
        end else begin
            g = model_grant();
            new_flag = exp_flag & ~ovf_clr;
            if (exp_valid && exp_ovf) new_flag[exp_id] = 1'b1;
            cyc++;
            if (g >= 0) begin
                q.push_back('{g, bus.req_x1[32*g +: 32], bus.req_x2[32*g +: 32], cyc + LAT - 1});
                m_rr = (g + 1) % NREQ;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                r = ref_mul(q[0].a, q[0].b);
                exp_valid = 1'b1;
                exp_id = IDW'(q[0].id);
                exp_ovf = r[32];
                exp_y = r[31:0];
                void'(q.pop_front());
            end else begin
                exp_valid = 1'b0;
            end
            exp_flag = new_flag;
            exp_busy = (q.size() + int'(exp_valid)) != 0;
        end
    end

    always @(negedge clk) begin
        int mg;
        mg = model_grant();
        chk("req_ready", bus.req_ready, (mg < 0) ? 64'd0 : (64'd1 << mg));
        chk("rsp_valid", bus.rsp_valid, exp_valid);
        chk("rsp_id",    bus.rsp_id,    exp_id);
        chk("rsp_y",     bus.rsp_y,     exp_y);
        chk("rsp_ovf",   bus.rsp_ovf,   exp_ovf);
        chk("ovf_flag",  ovf_flag,      exp_flag);
        chk("busy",      busy,          exp_busy);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input bit gap);
        bit got = 1'b0;
        bus.req_x1[32*id +: 32] = a;
        bus.req_x2[32*id +: 32] = b;
        bus.req_valid[id] = 1'b1;
        if (gap) begin
            en = 1'b0;
            tick();
            tick();
            en = 1'b1;
        end
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.req_ready[id];
            tick();
        end
        bus.req_valid[id] = 1'b0;
        if (!got) fail("grant_timeout");
    endtask

    task automatic wait_rsp(output logic [31:0] y, output int id, output logic ovf, output int lat);
        bit seen = 1'b0;
        y = '0; id = 0; ovf = 1'b0; lat = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                seen = 1'b1;
                y = bus.rsp_y;
                id = int'(bus.rsp_id);
                ovf = bus.rsp_ovf;
            end
        end
        if (!seen) fail("rsp_timeout");
    endtask

    task automatic fairness(input bit gap);
        int seq[8];
        int ng = 0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x1[32*i +: 32] = 32'h3F80_0000 + (i << 20);
            bus.req_x2[32*i +: 32] = 32'h4040_0000 - (i << 19);
        end
        bus.req_valid = '1;
        for (int n = 0; n < 14 && ng < 8; n++) begin
            en = !(gap && (n == 4 || n == 5));
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i]) begin
                    seq[ng] = i;
                    ng++;
                end
            tick();
        end
        en = 1'b1;
        bus.req_valid = '0;
        if (ng < 8) fail("fair_count");
        for (int i = 0; i < 8; i++) chk($sformatf("fair_grant%0d", i), seq[i], i % NREQ);
        repeat (4) tick();
    endtask

    logic [31:0] y;
    int          id, lat, bcnt, vcnt;
    logic        ovf;

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        ovf_clr = '0;
        bus.req_valid = '0;
        bus.req_x1 = '0;
        bus.req_x2 = '0;

        chk("ref_one_two", ref_mul(32'h3F80_0000, 32'h4000_0000), {1'b0, 32'h4000_0000});
        chk("ref_round",   ref_mul(32'h3FC0_0000, 32'h3FC0_0000), {1'b0, 32'h4010_0000});
        chk("ref_sign",    ref_mul(32'hC000_0000, 32'h4040_0000), {1'b0, 32'hC0C0_0000});
        chk("ref_ovf",     ref_mul(32'h7F00_0000, 32'h7F00_0000), {1'b1, 32'h7F80_0000});
        chk("ref_zero",    ref_mul(32'h0000_0000, 32'h4000_0000), {1'b0, 32'h0000_0000});

        tick();
        en = 1'b1;
        do_reset();

        for (int pass = 0; pass < 2; pass++) begin
            bit gap;
            gap = (pass == 1);
            do_reset();
            fairness(gap);

            issue(0, 32'h3F80_0000, 32'h4000_0000, gap);
            wait_rsp(y, id, ovf, lat);
            chk("s1_lat", lat, LAT);
            chk("s1_id", id, 0);
            chk("s1_y", y, 32'h4000_0000);
            chk("s1_ovf", ovf, 1'b0);

            issue(1, 32'h3FC0_0000, 32'h3FC0_0000, gap);
            wait_rsp(y, id, ovf, lat);
            chk("s2_round", y, 32'h4010_0000);
            issue(2, 32'hC000_0000, 32'h4040_0000, gap);
            wait_rsp(y, id, ovf, lat);
            chk("s2_sign", y, 32'hC0C0_0000);

            issue(3, 32'h7F00_0000, 32'h7F00_0000, gap);
            wait_rsp(y, id, ovf, lat);
            chk("s4_ovf", ovf, 1'b1);
            @(negedge clk);
            chk("s4_sticky", ovf_flag[3], 1'b1);
            tick();
            issue(3, 32'h7F00_0000, 32'h7F00_0000, gap);
            wait_rsp(y, id, ovf, lat);
            ovf_clr[3] = 1'b1;
            tick();
            ovf_clr[3] = 1'b0;
            @(negedge clk);
            chk("s4_set_wins", ovf_flag[3], 1'b1);
            ovf_clr[3] = 1'b1;
            tick();
            ovf_clr[3] = 1'b0;
            @(negedge clk);
            chk("s4_clr", ovf_flag[3], 1'b0);
            tick();

            issue(0, 32'h0000_0000, 32'h4000_0000, gap);
            bcnt = 0;
            y = 32'hFFFF_FFFF;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (bus.rsp_valid) y = bus.rsp_y;
                if (!busy) break;
                bcnt++;
            end
            chk("s5_busy_len", bcnt, LAT);
            chk("s5_ftz", y, 32'h0000_0000);
            tick();

            issue(2, 32'h7F00_0000, 32'h4000_0000, gap);
            wait_rsp(y, id, ovf, lat);
            repeat (2) tick();
            if (gap) begin
                en = 1'b0;
                tick();
                en = 1'b1;
            end
            bus.req_x1[31:0] = 32'h4000_0000;
            bus.req_x2[31:0] = 32'h4000_0000;
            bus.req_x1[63:32] = 32'h4040_0000;
            bus.req_x2[63:32] = 32'h4040_0000;
            bus.req_valid[1:0] = 2'b11;
            vcnt = 0;
            for (int n = 0; n < 10 && vcnt < 2; n++) begin
                @(negedge clk);
                if (|bus.req_ready) vcnt++;
                tick();
            end
            if (vcnt < 2) fail("s6_accepts");
            rstn = 1'b0;
            bus.req_valid = '0;
            tick();
            rstn = 1'b1;
            vcnt = 0;
            bcnt = 0;
            @(negedge clk);
            chk("s6_flag", ovf_flag, '0);
            for (int n = 0; n < 5; n++) begin
                if (n > 0) @(negedge clk);
                vcnt += int'(bus.rsp_valid);
                bcnt += int'(busy);
            end
            chk("s6_no_rsp", vcnt, 0);
            chk("s6_busy", bcnt, 0);
            tick();
            bus.req_valid = '1;
            @(negedge clk);
            chk("s6_rr", bus.req_ready, 4'b0001);
            tick();
            bus.req_valid = '0;
            repeat (4) tick();
        end

        for (int n = 0; n < 12; n++) begin
            logic [31:0] a, b;
            a = {1'($urandom), 8'($urandom_range(70, 185)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(70, 185)), 23'($urandom)};
            issue($urandom_range(0, NREQ - 1), a, b, 1'b0);
        end
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
